// File: rtl/dbusif_pkg.sv
// Shared core definitions for the data-bus interface: access sizes, op codes,
// FSM states and the lane helpers used to build and decode bus beats.
package dbusif_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_R = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Naturally aligned byte/half/word only; the reserved size never reaches the bus.
    function automatic logic size_legal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return ~off[0];
            SIZE_W:  return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 4'b0001 << off;
            SIZE_H:  return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SIZE_B:  return {4{wd[7:0]}};
            SIZE_H:  return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            SIZE_B:  return {24'h0, sh[7:0]};
            SIZE_H:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dff.sv
// Plain register cell with asynchronous active-low clear.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/dbusif.sv
// Data-bus interface: turns a one-cycle load/store request into an aligned bus
// beat, waits for ack or timeout, and returns a single done/err/rd response.
module dbusif
    import dbusif_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dbusif_req,
    input  logic        dbusif_w_rb,
    input  logic [1:0]  dbusif_size,
    input  logic [31:0] dbusif_addr,
    input  logic [31:0] dbusif_wd,
    output logic        dbusif_done,
    output logic        dbusif_err,
    output logic [31:0] dbusif_rd,
    output logic        bus_req,
    output logic        bus_w_rb,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output state_e      dbg_state
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam int         OUT_W   = 1 + 1 + 32 + 1 + 1 + 32 + 4 + 32;

    state_e      state;
    logic [7:0]  cnt;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_w_rb;

    logic        legal;
    logic        accept;
    logic        ack_hit;
    logic        to_hit;

    logic        nxt_done;
    logic        nxt_err;
    logic [31:0] nxt_rd;
    logic        nxt_bus_req;
    logic        nxt_bus_w_rb;
    logic [31:0] nxt_bus_addr;
    logic [3:0]  nxt_bus_be;
    logic [31:0] nxt_bus_wdata;

    assign legal   = size_legal(dbusif_size, dbusif_addr[1:0]);
    assign accept  = (state == ST_IDLE) && dbusif_req;
    assign ack_hit = (state == ST_BUSY) && bus_ack;
    // Ack on the last allowed cycle still completes normally.
    assign to_hit  = (state == ST_BUSY) && !bus_ack && (cnt == TO_LAST);

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            lat_off  <= 2'b00;
            lat_size <= SIZE_B;
            lat_w_rb <= OP_READ;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbusif_req) begin
                        cnt      <= 8'd0;
                        lat_off  <= dbusif_addr[1:0];
                        lat_size <= dbusif_size;
                        lat_w_rb <= dbusif_w_rb;
                        state    <= legal ? ST_BUSY : ST_RESP;
                    end
                end
                ST_BUSY: begin
                    if (ack_hit || to_hit) state <= ST_RESP;
                    else                   cnt   <= cnt + 8'd1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response outputs are computed on the edge that enters RESP so done is
    // visible for exactly the RESP cycle.
    always_comb begin
        nxt_done      = (accept && !legal) || ack_hit || to_hit;
        nxt_err       = (accept && !legal) || (ack_hit && bus_err) || to_hit;
        nxt_rd        = 32'h0;
        if (ack_hit && !bus_err && (lat_w_rb == OP_READ))
            nxt_rd = lane_rdata(lat_size, lat_off, bus_rdata);

        nxt_bus_req   = (accept && legal) || ((state == ST_BUSY) && !ack_hit && !to_hit);
        nxt_bus_w_rb  = bus_w_rb;
        nxt_bus_addr  = bus_addr;
        nxt_bus_be    = bus_be;
        nxt_bus_wdata = bus_wdata;
        if (accept && legal) begin
            nxt_bus_w_rb  = dbusif_w_rb;
            nxt_bus_addr  = {dbusif_addr[31:2], 2'b00};
            nxt_bus_be    = lane_be(dbusif_size, dbusif_addr[1:0]);
            nxt_bus_wdata = lane_wdata(dbusif_size, dbusif_wd);
        end
    end

    dff #(.W(OUT_W)) u_out_regs (
        .clk  (clk),
        .rstn (rstn),
        .d    ({nxt_done, nxt_err, nxt_rd, nxt_bus_req, nxt_bus_w_rb,
                nxt_bus_addr, nxt_bus_be, nxt_bus_wdata}),
        .q    ({dbusif_done, dbusif_err, dbusif_rd, bus_req, bus_w_rb,
                bus_addr, bus_be, bus_wdata})
    );

endmodule

// File: doc/dbusif.md
DBUSIF -- requirements
Module: dbusif

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles bus_req stays high without bus_ack before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dbusif_req  input  1  one-cycle request pulse from stage_id.
REQ-005 SHALL have port dbusif_w_rb  input  1  1=write, 0=read.
REQ-006 SHALL have port dbusif_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-007 SHALL have port dbusif_addr  input  32  byte address.
REQ-008 SHALL have port dbusif_wd  input  32  write data, right-justified.
REQ-009 SHALL have port dbusif_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port dbusif_err  output  1  valid with done; 1=access failed.
REQ-011 SHALL have port dbusif_rd  output  32  read data, right-justified, zero-extended, valid with done.
REQ-012 SHALL have ports bus_req output 1, bus_w_rb output 1, bus_addr output 32 (bits[1:0]=0), bus_be output 4, bus_wdata output 32, all registered.
REQ-013 SHALL have ports bus_ack input 1, bus_err input 1 (valid with ack), bus_rdata input 32 (valid with ack).

Function
REQ-014 SHALL implement FSM IDLE, BUSY, RESP.
REQ-015 IDLE + dbusif_req + legal access -> BUSY; bus_req and bus_* fields registered, visible the next cycle.
REQ-016 Illegal access (size=3, half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1, no bus_req issued.
REQ-017 bus_be: byte=4'b0001<<addr[1:0]; half=4'b0011<<addr[1:0]; word=4'b1111.
REQ-018 bus_wdata: wd byte replicated x4 for byte, wd[15:0] replicated x2 for half, wd unchanged for word.
REQ-019 bus_req, bus_w_rb, bus_addr, bus_be, bus_wdata SHALL hold stable while in BUSY.
REQ-020 BUSY + bus_ack -> RESP; capture bus_err and lane-extracted rdata (shift right by 8*addr[1:0], mask to size); bus_req drops the same edge.
REQ-021 BUSY: 8-bit counter cleared on entry, increments each cycle without ack; when counter==TIMEOUT-1 and no ack -> RESP with err=1, bus_req dropped.
REQ-022 bus_ack and timeout in the same cycle: ack wins.
REQ-023 RESP: dbusif_done=1 for exactly one cycle, then IDLE; latency req->done = 2 + bus wait cycles for legal accesses, 1 for illegal.
REQ-024 dbusif_req while not IDLE SHALL be ignored (no queueing).
REQ-025 dbusif_rd SHALL be 0 on writes and on errors.
REQ-026 bus_ack while IDLE or RESP SHALL be ignored.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE, counter 0, and all outputs 0, including mid-transaction; no done is produced for an aborted access.

Structure
REQ-028 Size encodings (SIZE_B/H/W) and FSM state enum SHALL live in the shared core package alongside OP_* constants.
REQ-029 Output registers SHALL use the existing dff cell; no other sub-module.

Verification
REQ-030 Word read addr 0x1000, ack after 3 wait cycles, rdata 0xDEADBEEF -> bus_be=1111, done 5 cycles after req, rd=0xDEADBEEF, err=0.
REQ-031 Byte write addr 0x2003, wd 0x000000A5 -> bus_addr=0x2000, be=1000, wdata=0xA5A5A5A5, done err=0, rd=0.
REQ-032 Half read addr 0x3001 -> no bus_req, done next cycle with err=1.
REQ-033 Half read addr 0x3002, TIMEOUT=4, no ack -> bus_req high 4 cycles, then done err=1, rd=0.
REQ-034 Read in flight, rstn pulsed low -> bus_req and all outputs 0 immediately, no done after release.
REQ-035 Half read addr 0x4002, rdata 0x8001FFFF, bus_err=1 -> done err=1, rd=0.
